// File: rtl/imm_stage_if.sv
// imm_stage_if: handshake bundle for the immediate-generation stage.
//   Upstream side : in_valid, in_ready, in_inst, in_tag
//   Downstream side: out_valid, out_ready, out_imm, out_fmt, out_illegal,
//                    out_inst, out_tag
// The stage itself uses the slave modport; a driver/environment uses master.
interface imm_stage_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_inst;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   logic [2:0]       out_fmt;
   logic             out_illegal;
   logic [31:0]      out_inst;
   logic [TAG_W-1:0] out_tag;

   modport slave (
      input  in_valid, in_inst, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_inst, out_tag
   );

   modport master (
      output in_valid, in_inst, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_inst, out_tag
   );
endinterface

// File: rtl/imm_stage.sv
// imm_stage: registered RV32I/RV64I immediate generator with a 2-entry skid
// buffer. Decodes in_inst combinationally, stores the result on accept and
// presents the oldest entry on the out_* side.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (clears buffer and output data)
//   flush : empties the buffer next cycle, overriding any push/pop
//   bus   : imm_stage_if.slave (in_* upstream handshake, out_* downstream)
// out_fmt codes: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
module imm_stage #(
   parameter int XLEN     = 32,
   parameter int TAG_W    = 32,
   parameter bit EN_ZICSR = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   imm_stage_if.slave   bus
);

   localparam logic [6:0] OP_LOAD     = 7'b0000011;
   localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OP_IMM      = 7'b0010011;
   localparam logic [6:0] OP_AUIPC    = 7'b0010111;
   localparam logic [6:0] OP_STORE    = 7'b0100011;
   localparam logic [6:0] OP_OP       = 7'b0110011;
   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] OP_JALR     = 7'b1100111;
   localparam logic [6:0] OP_JAL      = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

   localparam logic [2:0] FMT_NONE  = 3'd0;
   localparam logic [2:0] FMT_I     = 3'd1;
   localparam logic [2:0] FMT_S     = 3'd2;
   localparam logic [2:0] FMT_B     = 3'd3;
   localparam logic [2:0] FMT_U     = 3'd4;
   localparam logic [2:0] FMT_J     = 3'd5;
   localparam logic [2:0] FMT_SHAMT = 3'd6;
   localparam logic [2:0] FMT_ZIMM  = 3'd7;

   // Occupancy of the buffer doubles as the control state.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic              in_ready_r;
   logic              out_valid_r;

   logic              push_s;
   logic              pop_s;
   logic              load_head_dec_s;
   logic              load_head_skid_s;
   logic              load_skid_s;

   logic [XLEN-1:0]   dec_imm_s;
   logic [2:0]        dec_fmt_s;
   logic              dec_ill_s;

   // Head entry drives the outputs directly; the skid slot holds the second entry.
   logic [XLEN-1:0]   head_imm_r;
   logic [2:0]        head_fmt_r;
   logic              head_ill_r;
   logic [31:0]       head_inst_r;
   logic [TAG_W-1:0]  head_tag_r;
   logic [XLEN-1:0]   skid_imm_r;
   logic [2:0]        skid_fmt_r;
   logic              skid_ill_r;
   logic [31:0]       skid_inst_r;
   logic [TAG_W-1:0]  skid_tag_r;

   logic [6:0]        opcode_s;
   logic [2:0]        funct3_s;

   assign opcode_s = bus.in_inst[6:0];
   assign funct3_s = bus.in_inst[14:12];

   // Immediate decode of the incoming instruction; sign source is always inst[31].
   always_comb begin
      dec_imm_s = {XLEN{1'b0}};
      dec_fmt_s = FMT_NONE;
      dec_ill_s = 1'b0;
      case (opcode_s)
         OP_IMM: begin
            if (funct3_s == 3'b001 || funct3_s == 3'b101) begin
               dec_fmt_s = FMT_SHAMT;
               dec_imm_s = (XLEN == 64) ? XLEN'(bus.in_inst[25:20])
                                        : XLEN'(bus.in_inst[24:20]);
            end else begin
               dec_fmt_s = FMT_I;
               dec_imm_s = XLEN'($signed(bus.in_inst[31:20]));
            end
         end
         OP_LOAD, OP_JALR: begin
            dec_fmt_s = FMT_I;
            dec_imm_s = XLEN'($signed(bus.in_inst[31:20]));
         end
         OP_STORE: begin
            dec_fmt_s = FMT_S;
            dec_imm_s = XLEN'($signed({bus.in_inst[31:25], bus.in_inst[11:7]}));
         end
         OP_BRANCH: begin
            dec_fmt_s = FMT_B;
            dec_imm_s = XLEN'($signed({bus.in_inst[31], bus.in_inst[7],
                                       bus.in_inst[30:25], bus.in_inst[11:8], 1'b0}));
         end
         OP_JAL: begin
            dec_fmt_s = FMT_J;
            dec_imm_s = XLEN'($signed({bus.in_inst[31], bus.in_inst[19:12],
                                       bus.in_inst[20], bus.in_inst[30:21], 1'b0}));
         end
         OP_LUI, OP_AUIPC: begin
            dec_fmt_s = FMT_U;
            dec_imm_s = XLEN'($signed({bus.in_inst[31:12], 12'h000}));
         end
         OP_SYSTEM: begin
            if (EN_ZICSR && funct3_s[2]) begin
               dec_fmt_s = FMT_ZIMM;
               dec_imm_s = XLEN'(bus.in_inst[19:15]);
            end else begin
               dec_fmt_s = FMT_NONE;
               dec_imm_s = {XLEN{1'b0}};
            end
         end
         OP_OP, OP_MISC_MEM: begin
            dec_fmt_s = FMT_NONE;
            dec_imm_s = {XLEN{1'b0}};
         end
         default: begin
            dec_ill_s = 1'b1;
         end
      endcase
   end

   assign push_s = bus.in_valid & in_ready_r;
   assign pop_s  = out_valid_r & bus.out_ready;

   // Next occupancy and which slots load this cycle; flush wins over push/pop.
   always_comb begin
      state_s          = state_r;
      load_head_dec_s  = 1'b0;
      load_head_skid_s = 1'b0;
      load_skid_s      = 1'b0;
      if (flush) begin
         state_s = ST_EMPTY;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (push_s) begin
                  load_head_dec_s = 1'b1;
                  state_s         = ST_ONE;
               end else begin
                  state_s = ST_EMPTY;
               end
            end
            ST_ONE: begin
               case ({push_s, pop_s})
                  2'b11:   load_head_dec_s = 1'b1;
                  2'b10: begin
                     load_skid_s = 1'b1;
                     state_s     = ST_FULL;
                  end
                  2'b01:   state_s = ST_EMPTY;
                  default: state_s = ST_ONE;
               endcase
            end
            ST_FULL: begin
               // in_ready is low while full, so only a pop can happen here.
               if (pop_s) begin
                  load_head_skid_s = 1'b1;
                  state_s          = ST_ONE;
               end else begin
                  state_s = ST_FULL;
               end
            end
            default: state_s = ST_EMPTY;
         endcase
      end
   end

   // Occupancy register plus the registered handshake outputs derived from it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_EMPTY;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         in_ready_r  <= (state_s != ST_FULL);
         out_valid_r <= (state_s != ST_EMPTY);
      end
   end

   // Head entry: only changes on refill, so it holds stable while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_imm_r  <= {XLEN{1'b0}};
         head_fmt_r  <= 3'd0;
         head_ill_r  <= 1'b0;
         head_inst_r <= 32'd0;
         head_tag_r  <= {TAG_W{1'b0}};
      end else if (load_head_dec_s) begin
         head_imm_r  <= dec_imm_s;
         head_fmt_r  <= dec_fmt_s;
         head_ill_r  <= dec_ill_s;
         head_inst_r <= bus.in_inst;
         head_tag_r  <= bus.in_tag;
      end else if (load_head_skid_s) begin
         head_imm_r  <= skid_imm_r;
         head_fmt_r  <= skid_fmt_r;
         head_ill_r  <= skid_ill_r;
         head_inst_r <= skid_inst_r;
         head_tag_r  <= skid_tag_r;
      end else begin
         head_imm_r  <= head_imm_r;
         head_fmt_r  <= head_fmt_r;
         head_ill_r  <= head_ill_r;
         head_inst_r <= head_inst_r;
         head_tag_r  <= head_tag_r;
      end
   end

   // Skid slot captures the second entry when the head is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_imm_r  <= {XLEN{1'b0}};
         skid_fmt_r  <= 3'd0;
         skid_ill_r  <= 1'b0;
         skid_inst_r <= 32'd0;
         skid_tag_r  <= {TAG_W{1'b0}};
      end else if (load_skid_s) begin
         skid_imm_r  <= dec_imm_s;
         skid_fmt_r  <= dec_fmt_s;
         skid_ill_r  <= dec_ill_s;
         skid_inst_r <= bus.in_inst;
         skid_tag_r  <= bus.in_tag;
      end else begin
         skid_imm_r  <= skid_imm_r;
         skid_fmt_r  <= skid_fmt_r;
         skid_ill_r  <= skid_ill_r;
         skid_inst_r <= skid_inst_r;
         skid_tag_r  <= skid_tag_r;
      end
   end

   assign bus.in_ready    = in_ready_r;
   assign bus.out_valid   = out_valid_r;
   assign bus.out_imm     = head_imm_r;
   assign bus.out_fmt     = head_fmt_r;
   assign bus.out_illegal = head_ill_r;
   assign bus.out_inst    = head_inst_r;
   assign bus.out_tag     = head_tag_r;

endmodule

// File: tb/tb_imm_stage.sv
// tb_imm_stage: directed and scoreboard bench for imm_stage, with one
// XLEN=32 (EN_ZICSR=1) instance and one XLEN=64 (EN_ZICSR=0) instance.
module tb_imm_stage;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   always #5 clk = ~clk;

   imm_stage_if #(.XLEN(32), .TAG_W(32)) bus32 ();
   imm_stage_if #(.XLEN(64), .TAG_W(32)) bus64 ();

   imm_stage #(.XLEN(32), .TAG_W(32), .EN_ZICSR(1'b1)) dut32 (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus32)
   );

   imm_stage #(.XLEN(64), .TAG_W(32), .EN_ZICSR(1'b0)) dut64 (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus64)
   );

   int checks = 0;
   int errors = 0;

   // Hand-computed XLEN=32 vectors: instruction, immediate, format, illegal.
   localparam int NV = 14;
   logic [31:0] v_inst [0:NV-1] = '{
      32'hFFF00093, 32'hFE000EE3, 32'h123452B7, 32'h3400D073, 32'h0000007F,
      32'hFE20AE23, 32'h0080006F, 32'h002081B3, 32'h03F09093, 32'h8000A083,
      32'h00000073, 32'h0000000F, 32'h00008067, 32'hFFFFF117};
   logic [31:0] v_imm [0:NV-1] = '{
      32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h00000001, 32'h00000000,
      32'hFFFFFFFC, 32'h00000008, 32'h00000000, 32'h0000001F, 32'hFFFFF800,
      32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFF000};
   logic [2:0] v_fmt [0:NV-1] = '{
      3'd1, 3'd3, 3'd4, 3'd7, 3'd0, 3'd2, 3'd5, 3'd0, 3'd6, 3'd1,
      3'd0, 3'd0, 3'd1, 3'd4};
   logic v_ill [0:NV-1] = '{
      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
      1'b0, 1'b0, 1'b0, 1'b0};

   typedef struct {
      int          idx;
      logic [31:0] tag;
   } ent_t;

   ent_t q [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset32(input string pfx);
      check({pfx, "_rdy"},  64'(bus32.in_ready),    64'd1);
      check({pfx, "_vld"},  64'(bus32.out_valid),   64'd0);
      check({pfx, "_imm"},  64'(bus32.out_imm),     64'd0);
      check({pfx, "_fmt"},  64'(bus32.out_fmt),     64'd0);
      check({pfx, "_ill"},  64'(bus32.out_illegal), 64'd0);
      check({pfx, "_inst"}, 64'(bus32.out_inst),    64'd0);
      check({pfx, "_tag"},  64'(bus32.out_tag),     64'd0);
   endtask

   task automatic check_head32(input string pfx, input int i);
      check({pfx, "_vld"},  64'(bus32.out_valid),   64'd1);
      check({pfx, "_imm"},  64'(bus32.out_imm),     64'(v_imm[i]));
      check({pfx, "_fmt"},  64'(bus32.out_fmt),     64'(v_fmt[i]));
      check({pfx, "_ill"},  64'(bus32.out_illegal), 64'(v_ill[i]));
      check({pfx, "_inst"}, 64'(bus32.out_inst),    64'(v_inst[i]));
   endtask

   task automatic accept32(input int i);
      bus32.out_ready = 1'b1;
      bus32.in_valid  = 1'b1;
      bus32.in_inst   = v_inst[i];
      bus32.in_tag    = 32'h1000 + 32'(i * 4);
      step();
      bus32.in_valid = 1'b0;
      check_head32($sformatf("acc%0d", i), i);
      check($sformatf("acc%0d_tag", i), 64'(bus32.out_tag), 64'(32'h1000 + 32'(i * 4)));
      step();
      check($sformatf("acc%0d_drain", i), 64'(bus32.out_valid), 64'd0);
   endtask

   task automatic accept64(input logic [31:0] inst, input logic [63:0] e_imm,
                           input logic [2:0] e_fmt, input logic e_ill);
      bus64.out_ready = 1'b1;
      bus64.in_valid  = 1'b1;
      bus64.in_inst   = inst;
      bus64.in_tag    = inst;
      step();
      bus64.in_valid = 1'b0;
      check($sformatf("x64_%h_vld", inst), 64'(bus64.out_valid),   64'd1);
      check($sformatf("x64_%h_imm", inst), bus64.out_imm,          e_imm);
      check($sformatf("x64_%h_fmt", inst), 64'(bus64.out_fmt),     64'(e_fmt));
      check($sformatf("x64_%h_ill", inst), 64'(bus64.out_illegal), 64'(e_ill));
      step();
   endtask

   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      bus32.in_valid = 1'b0; bus32.in_inst = 32'd0; bus32.in_tag = 32'd0; bus32.out_ready = 1'b0;
      bus64.in_valid = 1'b0; bus64.in_inst = 32'd0; bus64.in_tag = 32'd0; bus64.out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      check_reset32("rst");
      check("rst64_rdy", 64'(bus64.in_ready),  64'd1);
      check("rst64_vld", 64'(bus64.out_valid), 64'd0);
      check("rst64_imm", bus64.out_imm,        64'd0);

      // One accept per vector, each visible the cycle after acceptance.
      for (int i = 0; i < NV; i++) accept32(i);

      // XLEN=64 sign extension, 6-bit shamt, and SYSTEM without Zicsr.
      accept64(32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
      accept64(32'h03F09093, 64'd63,               3'd6, 1'b0);
      accept64(32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
      accept64(32'h3400D073, 64'd0,                3'd0, 1'b0);

      // Back-pressure: three offered with out_ready low, only two accepted.
      bus32.out_ready = 1'b0;
      bus32.in_valid  = 1'b1;
      bus32.in_inst   = v_inst[0];
      step();
      check("bp1_rdy", 64'(bus32.in_ready), 64'd1);
      check_head32("bp1", 0);
      bus32.in_inst = v_inst[1];
      step();
      check("bp2_rdy", 64'(bus32.in_ready), 64'd0);
      check_head32("bp2", 0);
      bus32.in_inst = v_inst[2];
      for (int k = 0; k < 2; k++) begin
         step();
         check($sformatf("bp_hold%0d_rdy", k), 64'(bus32.in_ready), 64'd0);
         check_head32($sformatf("bp_hold%0d", k), 0);
      end
      bus32.out_ready = 1'b1;
      step();
      check("bp_rel1_rdy", 64'(bus32.in_ready), 64'd1);
      check_head32("bp_rel1", 1);
      step();
      check_head32("bp_rel2", 2);
      bus32.in_valid = 1'b0;
      step();
      check("bp_rel3_vld", 64'(bus32.out_valid), 64'd0);

      // Flush while full with in_valid high.
      bus32.out_ready = 1'b0;
      bus32.in_valid  = 1'b1;
      bus32.in_inst   = v_inst[3];
      step();
      bus32.in_inst = v_inst[4];
      step();
      check("fl_full_rdy", 64'(bus32.in_ready), 64'd0);
      flush = 1'b1;
      bus32.out_ready = 1'b1;
      bus32.in_inst   = v_inst[5];
      step();
      flush = 1'b0;
      bus32.in_valid = 1'b0;
      check("fl_full_vld", 64'(bus32.out_valid), 64'd0);
      check("fl_full_rdy2", 64'(bus32.in_ready), 64'd1);
      step();
      check("fl_full_vld2", 64'(bus32.out_valid), 64'd0);

      // Flush with one entry while an accept happens in the same cycle.
      bus32.out_ready = 1'b0;
      bus32.in_valid  = 1'b1;
      bus32.in_inst   = v_inst[6];
      step();
      flush = 1'b1;
      bus32.in_inst = v_inst[7];
      step();
      flush = 1'b0;
      bus32.in_valid = 1'b0;
      check("fl_one_vld", 64'(bus32.out_valid), 64'd0);
      step();
      check("fl_one_vld2", 64'(bus32.out_valid), 64'd0);
      accept32(8);

      // Random stream against a queue model, with flushes and one reset pulse.
      for (int c = 0; c < 400; c++) begin
         logic do_push;
         logic do_pop;
         ent_t e;
         check("rnd_rdy", 64'(bus32.in_ready),  64'(q.size() != 2));
         check("rnd_vld", 64'(bus32.out_valid), 64'(q.size() != 0));
         if (q.size() != 0) begin
            check($sformatf("rnd%0d_inst", c), 64'(bus32.out_inst), 64'(v_inst[q[0].idx]));
            check($sformatf("rnd%0d_imm", c),  64'(bus32.out_imm),  64'(v_imm[q[0].idx]));
            check($sformatf("rnd%0d_fmt", c),  64'(bus32.out_fmt),  64'(v_fmt[q[0].idx]));
            check($sformatf("rnd%0d_tag", c),  64'(bus32.out_tag),  64'(q[0].tag));
         end
         e.idx = int'($urandom_range(NV - 1, 0));
         e.tag = $urandom;
         bus32.in_valid  = ($urandom_range(3, 0) != 0);
         bus32.in_inst   = v_inst[e.idx];
         bus32.in_tag    = e.tag;
         bus32.out_ready = ($urandom_range(2, 0) != 0);
         flush = ($urandom_range(31, 0) == 0);
         rst   = (c == 200);
         do_push = bus32.in_valid && (q.size() != 2);
         do_pop  = bus32.out_ready && (q.size() != 0);
         if (rst || flush) begin
            q.delete();
         end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(e);
         end
         step();
         if (rst) begin
            rst = 1'b0;
            check_reset32("midrst");
         end
         flush = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
